mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between instruction fetch (IF) and the
//  MEM-stage data access of the 5-stage pipeline. One transaction is in flight at a time.
//  Requesters hold their request until they see a one-cycle ready pulse. The pipeline
//  stalls the IF/ID and EX/MEM registers while their request is pending without ready.
// PARAMETERS
//  LATENCY       1  cycles from the ram_en cycle to ram_rdata valid; legal range >=1
//  STARVE_LIMIT  4  consecutive MEM grants with if_req pending before IF is forced; >=1
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  if_req         in   1   IF read request, held until if_ready
//  if_addr        in   32  IF byte address
//  if_flush       in   1   branch redirect: discard the in-flight IF result
//  if_ready       out  1   1-cycle pulse: if_rdata valid
//  if_rdata       out  32  fetched instruction, holds between pulses
//  mem_req_read   in   1   MEM-stage load request, held until mem_ready
//  mem_req_write  in   1   MEM-stage store request, held until mem_ready
//  mem_addr       in   32  MEM byte address
//  mem_wdata      in   32  store data
//  mem_ready      out  1   1-cycle pulse: access complete
//  mem_rdata      out  32  load data, holds between pulses; not updated by stores
//  ram_en         out  1   RAM access strobe, exactly one cycle per transaction
//  ram_we         out  1   RAM write enable, qualified by ram_en
//  ram_addr       out  32  RAM address, registered
//  ram_wdata      out  32  RAM write data, registered
//  ram_rdata      in   32  RAM read data, valid LATENCY cycles after the ram_en cycle
//  busy           out  1   1 in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; wait counter and starvation counter cleared;
//    kill flag cleared. rst mid-transaction aborts it: no ready pulse, ram_en low the
//    next cycle.
//  - FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered.
//  - IDLE: sample the requests at the clock edge. The MEM request is
//    mem_req_read|mem_req_write.
//    - Only one requester pending: grant it.
//    - Both pending: grant MEM, unless starve_cnt==STARVE_LIMIT; then grant IF.
//    - On a grant, latch owner, ram_addr, ram_we and ram_wdata, then go to ISSUE.
//    - ram_we = mem_req_write for a MEM grant; a MEM grant with read and write both set
//      is treated as a write. An IF grant always gives ram_we=0.
//  - ISSUE: ram_en=1 for this single cycle. Load wait_cnt=LATENCY, then go to WAIT.
//  - WAIT: decrement wait_cnt each cycle. On the edge where wait_cnt==1, capture
//    ram_rdata into if_rdata (IF owner) or mem_rdata (MEM read owner), then go to DONE.
//  - DONE: pulse the owner's ready for one cycle. Requests are ignored in DONE, so a
//    held request cannot issue twice. Next state is IDLE.
//  - Timing: request sampled at edge E0 -> ram_en in the cycle after E0 -> ready high in
//    the cycle after edge E0+LATENCY+1. A back-to-back grant is possible on the edge
//    ending DONE+1 (IDLE) at the earliest.
//  - Starvation counter: increments on each MEM grant taken while if_req=1, saturating at
//    STARVE_LIMIT. It clears on any IF grant, and on a MEM grant taken with if_req=0.
//  - Flush: if_flush=1 in IDLE with IF granted, or in ISSUE/WAIT/DONE with IF owner, sets
//    the kill flag.
//    - if_rdata is still updated; the if_ready pulse is suppressed.
//    - The RAM access is not cancelled.
//    - The kill flag clears on entry to IDLE.
//  - if_flush has no effect on a MEM-owned transaction.
//  - No new request is sampled outside IDLE. Address and data changes outside IDLE are
//    ignored.
// TESTING
//  1. LATENCY=1, if_req=1 if_addr=0x40 at E0; RAM returns 0x8C010004 -> ram_en in cycle 1;
//     if_ready=1 with if_rdata=0x8C010004 in cycle 3 only.
//  2. mem_req_write=1 addr=0x100 wdata=0xDEADBEEF -> one ram_en cycle with ram_we=1;
//     mem_ready pulses once; mem_rdata unchanged.
//  3. Both requests held continuously, STARVE_LIMIT=4 -> grant order MEM,MEM,MEM,MEM,IF,
//     MEM..., with exactly one ram_en per grant.
//  4. IF in WAIT with LATENCY=3, if_flush pulsed -> no if_ready pulse; busy returns to 0;
//     the next if_req is served normally.
//  5. rst asserted during WAIT -> the next cycle shows IDLE, busy=0, ram_en=0, no ready;
//     a subsequent mem_req_read completes normally.
//  6. mem_req_read held through mem_ready -> exactly one ram_en and one pulse; a second
//     access issues only after IDLE resamples the request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the MEM stage.
// One transaction in flight; MEM has priority except when IF has been starved too long.
module mem_port_arbiter #(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        mem_req_read,
  input  logic        mem_req_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam int WW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_LOAD  = WW'(LATENCY);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_r, state_s;
  logic            owner_mem_r, owner_mem_s;
  logic            kill_r, kill_s;
  logic [WW-1:0]   wait_cnt_r, wait_cnt_s;
  logic [SW-1:0]   starve_cnt_r, starve_cnt_s;
  logic            ram_en_r, ram_en_s;
  logic            ram_we_r, ram_we_s;
  logic [31:0]     ram_addr_r, ram_addr_s;
  logic [31:0]     ram_wdata_r, ram_wdata_s;
  logic            if_ready_r, if_ready_s;
  logic            mem_ready_r, mem_ready_s;
  logic [31:0]     if_rdata_r, if_rdata_s;
  logic [31:0]     mem_rdata_r, mem_rdata_s;
  logic            busy_r, busy_s;
  logic            mem_req_s;
  logic            grant_mem_s;
  logic            flush_hit_s;

  assign mem_req_s   = mem_req_read | mem_req_write;
  // IF wins a tie only once MEM has taken STARVE_LIMIT grants in a row past it
  assign grant_mem_s = mem_req_s & ~(if_req & (starve_cnt_r == STARVE_MAX));
  assign flush_hit_s = if_flush & ~owner_mem_r;

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_s      = state_r;
    owner_mem_s  = owner_mem_r;
    kill_s       = kill_r;
    wait_cnt_s   = wait_cnt_r;
    starve_cnt_s = starve_cnt_r;
    ram_en_s     = 1'b0;
    ram_we_s     = ram_we_r;
    ram_addr_s   = ram_addr_r;
    ram_wdata_s  = ram_wdata_r;
    if_ready_s   = 1'b0;
    mem_ready_s  = 1'b0;
    if_rdata_s   = if_rdata_r;
    mem_rdata_s  = mem_rdata_r;
    case (state_r)
      IDLE: begin
        kill_s = 1'b0;
        if (grant_mem_s) begin
          state_s     = ISSUE;
          owner_mem_s = 1'b1;
          ram_en_s    = 1'b1;
          ram_we_s    = mem_req_write;
          ram_addr_s  = mem_addr;
          ram_wdata_s = mem_wdata;
          if (!if_req) begin
            starve_cnt_s = {SW{1'b0}};
          end else if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_s = starve_cnt_r + SW'(1);
          end else begin
            starve_cnt_s = starve_cnt_r;
          end
        end else if (if_req) begin
          state_s      = ISSUE;
          owner_mem_s  = 1'b0;
          ram_en_s     = 1'b1;
          ram_we_s     = 1'b0;
          ram_addr_s   = if_addr;
          ram_wdata_s  = 32'h0000_0000;
          starve_cnt_s = {SW{1'b0}};
          kill_s       = if_flush;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s    = WAIT;
        wait_cnt_s = WAIT_LOAD;
        kill_s     = kill_r | flush_hit_s;
      end
      WAIT: begin
        wait_cnt_s = wait_cnt_r - WW'(1);
        kill_s     = kill_r | flush_hit_s;
        if (wait_cnt_r == WW'(1)) begin
          state_s = DONE;
          if (owner_mem_r) begin
            mem_ready_s = 1'b1;
            if (!ram_we_r) begin
              mem_rdata_s = ram_rdata;
            end else begin
              mem_rdata_s = mem_rdata_r;
            end
          end else begin
            // a flushed fetch still lands in if_rdata; only the pulse is withheld
            if_rdata_s = ram_rdata;
            if_ready_s = ~(kill_r | if_flush);
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
        kill_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        kill_s  = 1'b0;
      end
    endcase
  end

  assign busy_s = (state_s != IDLE);

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_mem_r  <= 1'b0;
      kill_r       <= 1'b0;
      wait_cnt_r   <= {WW{1'b0}};
      starve_cnt_r <= {SW{1'b0}};
      ram_en_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= 32'h0000_0000;
      ram_wdata_r  <= 32'h0000_0000;
      if_ready_r   <= 1'b0;
      mem_ready_r  <= 1'b0;
      if_rdata_r   <= 32'h0000_0000;
      mem_rdata_r  <= 32'h0000_0000;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      owner_mem_r  <= owner_mem_s;
      kill_r       <= kill_s;
      wait_cnt_r   <= wait_cnt_s;
      starve_cnt_r <= starve_cnt_s;
      ram_en_r     <= ram_en_s;
      ram_we_r     <= ram_we_s;
      ram_addr_r   <= ram_addr_s;
      ram_wdata_r  <= ram_wdata_s;
      if_ready_r   <= if_ready_s;
      mem_ready_r  <= mem_ready_s;
      if_rdata_r   <= if_rdata_s;
      mem_rdata_r  <= mem_rdata_s;
      busy_r       <= busy_s;
    end
  end

  assign if_ready  = if_ready_r;
  assign if_rdata  = if_rdata_r;
  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;
  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign busy      = busy_r;

endmodule
